// File: rtl/conv_frame_streamer_if.sv
// Port bundle for conv_frame_streamer: frame-load write port, frame config/control,
// and the pixel stream that feeds conv_buffer (in_point/valid_in/frame_column_size).
interface conv_frame_streamer_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int BUFFER_LENGTH = 2000,
    parameter int MAX_PIXELS    = 4096
);
    localparam int CW = $clog2(BUFFER_LENGTH);
    localparam int AW = $clog2(MAX_PIXELS);

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [CW-1:0]         cfg_column_size;
    logic [AW-1:0]         cfg_row_size;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  cfg_error;
    logic [DATA_WIDTH-1:0] out_point;
    logic                  valid_out;
    logic [CW-1:0]         frame_column_size;

    // The streamer is the master of the pixel stream.
    modport master (
        input  wr_en, wr_addr, wr_data, cfg_column_size, cfg_row_size, start,
        output busy, done, cfg_error, out_point, valid_out, frame_column_size
    );

    modport slave (
        output wr_en, wr_addr, wr_data, cfg_column_size, cfg_row_size, start,
        input  busy, done, cfg_error, out_point, valid_out, frame_column_size
    );
endinterface

// File: rtl/conv_frame_streamer.sv
// Frame store plus raster-order pixel streamer feeding conv_buffer.
// Optional inter-row idle gap enabled by defining CONV_STREAM_ROW_GAP_EN.
module conv_frame_streamer #(
    parameter int DATA_WIDTH     = 8,
    parameter int BUFFER_LENGTH  = 2000,
    parameter int MAX_PIXELS     = 4096,
    parameter int ROW_GAP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    conv_frame_streamer_if.master   bus
);
    localparam int CW = $clog2(BUFFER_LENGTH);
    localparam int AW = $clog2(MAX_PIXELS);
    localparam int PW = CW + AW;
    localparam int GW = (ROW_GAP_CYCLES > 1) ? $clog2(ROW_GAP_CYCLES) : 1;

`ifdef CONV_STREAM_ROW_GAP_EN
    localparam bit ROW_GAP_EN = 1'b1;
`else
    localparam bit ROW_GAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        STREAM,
        GAP,
        DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cols_reg, cols_next;
    logic [AW-1:0]   rows_reg, rows_next;
    logic [CW-1:0]   col_reg, col_next;
    logic [AW-1:0]   row_reg, row_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            cfg_error_reg, cfg_error_next;
    logic            rd_en;
    logic [PW-1:0]   cfg_pixels;
    logic            last_col;
    logic            last_row;

    logic [DATA_WIDTH-1:0] mem [MAX_PIXELS];
    logic [DATA_WIDTH-1:0] out_point_reg;
    logic                  valid_reg;

    // Full-width product so oversize configs can never alias down to a legal size.
    assign cfg_pixels = PW'(bus.cfg_column_size) * PW'(bus.cfg_row_size);
    assign last_col   = (col_reg == cols_reg - 1'b1);
    assign last_row   = (row_reg == rows_reg - 1'b1);

    always_comb begin
        state_next     = state_reg;
        cols_next      = cols_reg;
        rows_next      = rows_reg;
        col_next       = col_reg;
        row_next       = row_reg;
        addr_next      = addr_reg;
        gap_cnt_next   = gap_cnt_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        cfg_error_next = cfg_error_reg;
        rd_en          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    cols_next      = bus.cfg_column_size;
                    rows_next      = bus.cfg_row_size;
                    cfg_error_next = 1'b0;
                    busy_next      = 1'b1;
                    col_next       = '0;
                    row_next       = '0;
                    addr_next      = '0;
                    if (bus.cfg_column_size == '0 || bus.cfg_row_size == '0 ||
                        cfg_pixels > PW'(MAX_PIXELS)) begin
                        cfg_error_next = 1'b1;
                        state_next     = DONE;
                    end else begin
                        state_next = PRIME;
                    end
                end
            end
            // Each cycle here issues one read; the pixel appears one cycle later.
            PRIME, STREAM: begin
                rd_en = 1'b1;
                if (last_col) begin
                    col_next = '0;
                    if (last_row) begin
                        state_next = DONE;
                    end else begin
                        row_next  = row_reg + 1'b1;
                        addr_next = addr_reg + 1'b1;
                        if (ROW_GAP_EN && ROW_GAP_CYCLES > 0) begin
                            gap_cnt_next = '0;
                            state_next   = GAP;
                        end else begin
                            state_next = STREAM;
                        end
                    end
                end else begin
                    col_next   = col_reg + 1'b1;
                    addr_next  = addr_reg + 1'b1;
                    state_next = STREAM;
                end
            end
            // Gap length is measured at the output: ROW_GAP_CYCLES idle valid cycles.
            GAP: begin
                if (gap_cnt_reg == GW'(ROW_GAP_CYCLES - 1)) begin
                    state_next = STREAM;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cols_reg      <= '0;
            rows_reg      <= '0;
            col_reg       <= '0;
            row_reg       <= '0;
            addr_reg      <= '0;
            gap_cnt_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cfg_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cols_reg      <= cols_next;
            rows_reg      <= rows_next;
            col_reg       <= col_next;
            row_reg       <= row_next;
            addr_reg      <= addr_next;
            gap_cnt_reg   <= gap_cnt_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            cfg_error_reg <= cfg_error_next;
        end
    end

    // Writes only land while idle so an in-flight frame cannot be corrupted.
    always_ff @(posedge clk) begin
        if (bus.wr_en && state_reg == IDLE) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_point_reg <= '0;
            valid_reg     <= 1'b0;
        end else begin
            valid_reg <= rd_en;
            if (rd_en) begin
                out_point_reg <= mem[addr_reg];
            end
        end
    end

    assign bus.busy              = busy_reg;
    assign bus.done              = done_reg;
    assign bus.cfg_error         = cfg_error_reg;
    assign bus.out_point         = out_point_reg;
    assign bus.valid_out         = valid_reg;
    assign bus.frame_column_size = cols_reg;
endmodule

// File: tb/tb_conv_frame_streamer.sv
// Scoreboard bench for conv_frame_streamer: stimulus pushes expected pixels/done,
// a negedge monitor pops and compares whatever the streamer presents.
module tb_conv_frame_streamer;
    localparam int DW = 8;
    localparam int BL = 2000;
    localparam int MP = 4096;
    localparam int RG = 2;
`ifdef CONV_STREAM_ROW_GAP_EN
    localparam int GAP = RG;
`else
    localparam int GAP = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_frame_streamer_if #(.DATA_WIDTH(DW), .BUFFER_LENGTH(BL), .MAX_PIXELS(MP)) bus ();

    conv_frame_streamer #(
        .DATA_WIDTH(DW), .BUFFER_LENGTH(BL), .MAX_PIXELS(MP), .ROW_GAP_CYCLES(RG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit          is_done;
        bit          err;
        logic [7:0]  data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] ref_mem [MP];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.valid_out || bus.done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {30'd0, bus.done, bus.valid_out}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_done) begin
                    check("done_slot", {31'd0, bus.done}, 32'd1);
                    check("done_cfg_error", {31'd0, bus.cfg_error}, {31'd0, mon_e.err});
                end else begin
                    check("pixel_valid", {31'd0, bus.valid_out}, 32'd1);
                    check("pixel_data", {24'd0, bus.out_point}, {24'd0, mon_e.data});
                end
            end
        end
    end

    task automatic write_word(input int a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 12'(a);
        bus.wr_data = d;
        ref_mem[a]  = d;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    // Streams one frame; inject_at >= 0 pulses start+write mid-frame, abort_val >= 0
    // resets when that pixel value appears, wr_with_start writes mem[0] with the start.
    task automatic run_frame(input int cols, input int rows, input int inject_at,
                             input int abort_val, input bit wr_with_start,
                             input logic [7:0] wr_val);
        int p       = cols * rows;
        bit err     = (cols == 0) || (rows == 0) || (p > MP);
        int span    = err ? 0 : p + (rows - 1) * GAP;
        int first_v = -1;
        int done_at = -1;
        int nvalid  = 0;
        bit fcs_ok  = 1'b1;
        bit busy_ok = 1'b1;

        bus.start           = 1'b1;
        bus.cfg_column_size = 11'(cols);
        bus.cfg_row_size    = 12'(rows);
        if (wr_with_start) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = '0;
            bus.wr_data = wr_val;
            ref_mem[0]  = wr_val;
        end
        if (!err) begin
            for (int i = 0; i < p; i++) exp_q.push_back('{1'b0, 1'b0, ref_mem[i]});
        end
        exp_q.push_back('{1'b1, err, 8'd0});

        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        check("cfg_error_latch", {31'd0, bus.cfg_error}, {31'd0, err});
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);

        for (int idx = 0; idx <= span + 8; idx++) begin
            if (idx == inject_at) begin
                bus.start           = 1'b1;
                bus.cfg_column_size = 11'd1;
                bus.cfg_row_size    = 12'd1;
                bus.wr_en           = 1'b1;
                bus.wr_addr         = '0;
                bus.wr_data         = 8'hFF;
            end else begin
                bus.start = 1'b0;
                bus.wr_en = 1'b0;
            end
            if (bus.valid_out) begin
                if (first_v < 0) first_v = idx;
                nvalid++;
                if (abort_val >= 0 && {24'd0, bus.out_point} == 32'(abort_val)) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    check("abort_valid_low", {31'd0, bus.valid_out}, 32'd0);
                    check("abort_busy_low", {31'd0, bus.busy}, 32'd0);
                    check("abort_no_done", {31'd0, bus.done}, 32'd0);
                    rst = 1'b0;
                    exp_q.delete();
                    $display("frame cols=%0d rows=%0d aborted by reset at pixel value %0d",
                             cols, rows, abort_val);
                    return;
                end
            end
            if ({21'd0, bus.frame_column_size} !== 32'(cols)) fcs_ok = 1'b0;
            if (bus.done) begin
                done_at = idx;
                check("busy_drops_with_done", {31'd0, bus.busy}, 32'd0);
                break;
            end else if (bus.busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;

        if (abort_val >= 0) check("abort_value_seen", 32'd0, 32'd1);
        if (err) check("no_pixels_on_error", 32'(nvalid), 32'd0);
        else     check("first_valid_latency", 32'(first_v), 32'd1);
        check("valid_count", 32'(nvalid), err ? 32'd0 : 32'(p));
        check("done_cycle", 32'(done_at), err ? 32'd1 : 32'(span + 1));
        check("column_size_held", {31'd0, fcs_ok}, 32'd1);
        check("busy_until_done", {31'd0, busy_ok}, 32'd1);
        if (done_at < 0) exp_q.delete();

        @(posedge clk); #1;
        check("done_single_pulse", {31'd0, bus.done}, 32'd0);
        check("column_size_after_done", {21'd0, bus.frame_column_size}, 32'(cols));
        $display("frame cols=%0d rows=%0d pixels=%0d err=%0d first_valid=%0d done_at=%0d",
                 cols, rows, nvalid, err, first_v, done_at);
    endtask

    initial begin
        int c;
        int r;
        bus.wr_en           = 1'b0;
        bus.wr_addr         = '0;
        bus.wr_data         = '0;
        bus.cfg_column_size = '0;
        bus.cfg_row_size    = '0;
        bus.start           = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'd0, bus.valid_out}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_cfg_error", {31'd0, bus.cfg_error}, 32'd0);
        check("reset_out_point", {24'd0, bus.out_point}, 32'd0);
        check("reset_col_size", {21'd0, bus.frame_column_size}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 36; i++) write_word(i, 8'(i + 1));
        run_frame(6, 6, -1, -1, 1'b0, 8'd0);
        run_frame(0, 4, -1, -1, 1'b0, 8'd0);
        run_frame(6, 6, 10, -1, 1'b0, 8'd0);
        run_frame(6, 6, -1, -1, 1'b0, 8'd0);
        run_frame(6, 6, -1, 10, 1'b0, 8'd0);
        run_frame(6, 6, -1, -1, 1'b0, 8'd0);
        run_frame(3, 2, -1, -1, 1'b0, 8'd0);
        run_frame(1, 1, -1, -1, 1'b0, 8'd0);
        run_frame(2, 2, -1, -1, 1'b1, 8'hA5);
        run_frame(5, 0, -1, -1, 1'b0, 8'd0);

        for (int i = 0; i < MP; i++) write_word(i, 8'($urandom));
        run_frame(64, 64, -1, -1, 1'b0, 8'd0);
        run_frame(64, 65, -1, -1, 1'b0, 8'd0);
        run_frame(2000, 2, -1, -1, 1'b0, 8'd0);

        for (int k = 0; k < 6; k++) begin
            c = $urandom_range(1, 70);
            r = $urandom_range(1, (MP / c < 9) ? MP / c : 9);
            run_frame(c, r, -1, -1, 1'b0, 8'd0);
        end
        for (int k = 0; k < 3; k++) begin
            c = $urandom_range(100, 2047);
            r = $urandom_range(41, 4095);
            run_frame(c, r, -1, -1, 1'b0, 8'd0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
